// File: rtl/axis_dac_player_pkg.sv
// Shared definitions for the BRAM waveform player: FSM encoding and DAC
// sample packing constants.
package axis_dac_player_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int DAC_DATA_WIDTH = 14;
    localparam int LANE_A_OFFSET  = 0;

    // Sample B sits in the upper half of each stream word.
    function automatic int lane_b_offset(input int tdata_width);
        return tdata_width / 2;
    endfunction

endpackage

// File: rtl/axis_dac_player_fifo.sv
// First-word-fall-through synchronous FIFO buffering BRAM returns ahead of
// the stream output register; occupancy feeds the read-credit logic.
module axis_dac_player_fifo
    import axis_dac_player_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Qualify requests so the FIFO can never over- or underflow.
    always_comb begin
        empty_s = (count_r == {(PW + 1){1'b0}});
        full_s  = (count_r == FULL_CNT);
        pop_s   = pop && !empty_s;
        push_s  = push && (!full_s || pop_s);
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge aclk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/axis_dac_player.sv
// BRAM waveform playback engine: streams packed DAC sample pairs from BRAM
// onto an AXI4-Stream master with configurable length and loop count.
module axis_dac_player
    import axis_dac_player_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_ADDR_WIDTH  = 12,
    parameter int READ_LATENCY     = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [BRAM_ADDR_WIDTH:0]      cfg_length,
    input  logic [15:0]                   cfg_loops,
    input  logic                          trig,
    input  logic                          stop,
    output logic                          busy,
    output logic [BRAM_ADDR_WIDTH-1:0]    sts_addr,
    output logic [15:0]                   sts_loops,
    output logic                          bram_porta_clk,
    output logic                          bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]    bram_porta_addr,
    input  logic [AXIS_TDATA_WIDTH-1:0]   bram_porta_rddata,
    input  logic                          m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int LW = BRAM_ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = CW + 1;
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);
    localparam logic [IW-1:0] DEPTH_IW = IW'(FIFO_DEPTH);

    logic [1:0]                    state_r;
    logic                          busy_r;
    logic                          trig_r;
    logic [LW-1:0]                 len_r;
    logic [15:0]                   loops_r;
    logic [AW-1:0]                 next_addr_r;
    logic [AW-1:0]                 addr_r;
    logic [AW-1:0]                 sts_addr_r;
    logic [15:0]                   sts_loops_r;
    logic                          addr_vld_r;
    logic [READ_LATENCY-1:0]       pipe_r;
    logic                          tvalid_r;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_r;

    logic [LW-1:0]                 len_s;
    logic [15:0]                   loops_s;
    logic [AW-1:0]                 cur_addr_s;
    logic [15:0]                   done_s;
    logic [15:0]                   pass_s;
    logic                          last_s;
    logic                          final_s;
    logic [IW-1:0]                 inflight_s;
    logic                          credit_s;
    logic                          load_s;
    logic                          pop_s;
    logic                          drained_s;
    logic                          trig_edge_s;
    logic                          start_s;
    logic                          issue_s;

    logic [AXIS_TDATA_WIDTH-1:0]   fifo_head_s;
    logic                          fifo_empty_s;
    logic [CW-1:0]                 fifo_count_s;

    // Issue decision. In IDLE the start edge issues address 0 using the live
    // cfg values, which is what makes the first beat land on time.
    always_comb begin
        len_s       = (state_r == ST_IDLE) ? cfg_length : len_r;
        loops_s     = (state_r == ST_IDLE) ? cfg_loops : loops_r;
        cur_addr_s  = (state_r == ST_IDLE) ? {AW{1'b0}} : next_addr_r;
        done_s      = (state_r == ST_IDLE) ? 16'd0 : sts_loops_r;
        pass_s      = done_s + 16'd1;
        last_s      = ({1'b0, cur_addr_s} == (len_s - LEN_ONE));
        final_s     = last_s && (loops_s != 16'd0) && (pass_s == loops_s);
        inflight_s  = IW'(addr_vld_r);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight_s = inflight_s + IW'(pipe_r[i]);
        end
        load_s      = !tvalid_r || m_axis_tready;
        pop_s       = load_s && !fifo_empty_s && !stop;
        // Credit counts the slot freed by this cycle's pop so steady-state
        // playback issues every cycle.
        credit_s    = ((IW'(fifo_count_s) + inflight_s) < (DEPTH_IW + IW'(pop_s)));
        drained_s   = !addr_vld_r && (pipe_r == {READ_LATENCY{1'b0}}) && fifo_empty_s && load_s;
        trig_edge_s = trig && !trig_r;
        start_s     = (state_r == ST_IDLE) && trig_edge_s && !stop && (cfg_length != {LW{1'b0}});
        case (state_r)
            ST_IDLE: issue_s = start_s;
            ST_PLAY: issue_s = credit_s && !stop;
            default: issue_s = 1'b0;
        endcase
    end

    // Playback FSM, address generation and status counters.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            trig_r      <= 1'b0;
            len_r       <= {LW{1'b0}};
            loops_r     <= 16'd0;
            next_addr_r <= {AW{1'b0}};
            addr_r      <= {AW{1'b0}};
            sts_addr_r  <= {AW{1'b0}};
            sts_loops_r <= 16'd0;
        end else begin
            trig_r <= trig;
            if (stop) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                if (issue_s) begin
                    addr_r      <= cur_addr_s;
                    sts_addr_r  <= cur_addr_s;
                    next_addr_r <= last_s ? {AW{1'b0}} : (cur_addr_s + AW'(1));
                end
                if (issue_s && last_s) begin
                    sts_loops_r <= pass_s;
                end else if (start_s) begin
                    sts_loops_r <= 16'd0;
                end
                case (state_r)
                    ST_IDLE: begin
                        if (start_s) begin
                            len_r   <= cfg_length;
                            loops_r <= cfg_loops;
                            busy_r  <= 1'b1;
                            state_r <= final_s ? ST_DRAIN : ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (issue_s && final_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drained_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // In-flight tracking: address-valid stage followed by the BRAM latency.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_vld_r <= 1'b0;
            pipe_r     <= {READ_LATENCY{1'b0}};
        end else if (stop) begin
            addr_vld_r <= 1'b0;
            pipe_r     <= {READ_LATENCY{1'b0}};
        end else begin
            addr_vld_r <= issue_s;
            pipe_r[0]  <= addr_vld_r;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    axis_dac_player_fifo #(
        .WIDTH (AXIS_TDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .flush     (stop),
        .push      (pipe_r[READ_LATENCY-1]),
        .push_data (bram_porta_rddata),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Registered stream output; holds data stable while stalled.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {AXIS_TDATA_WIDTH{1'b0}};
        end else if (stop) begin
            tvalid_r <= 1'b0;
        end else if (load_s) begin
            tvalid_r <= !fifo_empty_s;
            if (!fifo_empty_s) begin
                tdata_r <= fifo_head_s;
            end
        end
    end

    assign busy            = busy_r;
    assign sts_addr        = sts_addr_r;
    assign sts_loops       = sts_loops_r;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = areset;
    assign bram_porta_addr = addr_r;
    assign m_axis_tdata    = tdata_r;
    assign m_axis_tvalid   = tvalid_r;

endmodule

// File: tb/tb_axis_dac_player.sv
// Directed self-checking bench for axis_dac_player with a behavioural BRAM.
module tb_axis_dac_player;

    localparam int AW = 12;
    localparam int LW = AW + 1;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic [LW-1:0] cfg_length;
    logic [15:0]   cfg_loops;
    logic          trig;
    logic          stop;
    logic          busy;
    logic [AW-1:0] sts_addr;
    logic [15:0]   sts_loops;
    logic          bram_clk;
    logic          bram_rst;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rddata;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tvalid;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_p [L];
    logic [DW-1:0] beat_q [$];
    int first_k;
    int busy_fall_k;

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        rd_p[0] <= mem[bram_addr];
        for (int i = 1; i < L; i++) rd_p[i] <= rd_p[i-1];
    end
    assign bram_rddata = rd_p[L-1];

    axis_dac_player #(
        .AXIS_TDATA_WIDTH (DW),
        .BRAM_ADDR_WIDTH  (AW),
        .READ_LATENCY     (L),
        .FIFO_DEPTH       (4)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .cfg_length        (cfg_length),
        .cfg_loops         (cfg_loops),
        .trig              (trig),
        .stop              (stop),
        .busy              (busy),
        .sts_addr          (sts_addr),
        .sts_loops         (sts_loops),
        .bram_porta_clk    (bram_clk),
        .bram_porta_rst    (bram_rst),
        .bram_porta_addr   (bram_addr),
        .bram_porta_rddata (bram_rddata),
        .m_axis_tready     (tready),
        .m_axis_tdata      (tdata),
        .m_axis_tvalid     (tvalid)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start_trig(input int len, input int loops);
        cfg_length = LW'(len);
        cfg_loops  = 16'(loops);
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic run_capture(input int max_cycles);
        beat_q.delete();
        first_k = -1;
        busy_fall_k = -1;
        for (int k = 1; k <= max_cycles; k++) begin
            tick();
            if (tvalid === 1'b1 && tready === 1'b1) begin
                if (first_k < 0) first_k = k;
                beat_q.push_back(tdata);
            end
            if (busy === 1'b0) begin
                busy_fall_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [DW+AW+AW+17:0] got;
        areset = 1'b1; trig = 1'b0; stop = 1'b0; tready = 1'b1;
        cfg_length = LW'(4); cfg_loops = 16'd1;
        repeat (3) @(posedge aclk);
        #1;
        got = {busy, tvalid, tdata, bram_addr, sts_addr, sts_loops};
        checks++;
        if (got !== '0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0", got);
        end
        checks++;
        if (bram_rst !== 1'b1 || bram_clk !== aclk) begin
            failures++; $display("FAIL bram_passthru: rst=%b clk=%b want rst=1 clk=%b", bram_rst, bram_clk, aclk);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            failures++; $display("FAIL post_reset_idle: busy=%b tvalid=%b want 0 0", busy, tvalid);
        end
    endtask

    task automatic test_single_pass();
        start_trig(4, 1);
        checks++;
        if (busy !== 1'b1 || tvalid !== 1'b0) begin
            failures++; $display("FAIL single_start: busy=%b tvalid=%b want 1 0", busy, tvalid);
        end
        run_capture(30);
        checks++;
        if (first_k != L + 2) begin
            failures++; $display("FAIL single_latency: got %0d want %0d", first_k, L + 2);
        end
        checks++;
        if (beat_q.size() != 4) begin
            failures++; $display("FAIL single_count: got %0d want 4", beat_q.size());
        end
        for (int i = 0; i < beat_q.size() && i < 4; i++) begin
            checks++;
            if (beat_q[i] !== DW'(i)) begin
                failures++; $display("FAIL single_data[%0d]: got %0d want %0d", i, beat_q[i], i);
            end
        end
        checks++;
        if (busy_fall_k != 8) begin
            failures++; $display("FAIL single_busy_fall: got %0d want 8", busy_fall_k);
        end
        checks++;
        if (sts_loops !== 16'd1 || sts_addr !== AW'(3) || tvalid !== 1'b0) begin
            failures++; $display("FAIL single_status: loops=%0d addr=%0d tvalid=%b want 1 3 0", sts_loops, sts_addr, tvalid);
        end
    endtask

    task automatic test_loop();
        start_trig(3, 0);
        repeat (3) tick();
        for (int n = 0; n < 100; n++) begin
            tick();
            checks++;
            if (tvalid !== 1'b1 || tdata !== DW'(n % 3)) begin
                failures++; $display("FAIL loop_beat[%0d]: tvalid=%b data=%0d want 1 %0d", n, tvalid, tdata, n % 3);
            end
            checks++;
            if (sts_loops !== 16'((n + 5) / 3)) begin
                failures++; $display("FAIL loop_count[%0d]: got %0d want %0d", n, sts_loops, (n + 5) / 3);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL loop_stop: tvalid=%b busy=%b want 0 0", tvalid, busy);
        end
    endtask

    task automatic test_abort();
        int stale;
        start_trig(8, 0);
        repeat (3) tick();
        repeat (6) tick();
        checks++;
        if (tvalid !== 1'b1 || tdata !== DW'(5)) begin
            failures++; $display("FAIL abort_beat5: tvalid=%b data=%0d want 1 5", tvalid, tdata);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || sts_loops !== 16'd1) begin
            failures++; $display("FAIL abort_next: tvalid=%b busy=%b loops=%0d want 0 0 1", tvalid, busy, sts_loops);
        end
        stale = 0;
        repeat (6) begin
            tick();
            if (tvalid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++; $display("FAIL abort_stale: got %0d active cycles want 0", stale);
        end
        start_trig(8, 1);
        run_capture(40);
        checks++;
        if (first_k != L + 2 || beat_q.size() != 8) begin
            failures++; $display("FAIL abort_restart: first=%0d beats=%0d want %0d 8", first_k, beat_q.size(), L + 2);
        end
        for (int i = 0; i < beat_q.size() && i < 8; i++) begin
            checks++;
            if (beat_q[i] !== DW'(i)) begin
                failures++; $display("FAIL abort_restart_data[%0d]: got %0d want %0d", i, beat_q[i], i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int beats;
        logic prev_stall;
        logic done;
        pat = 4'b1001;
        beats = 0;
        prev_stall = 1'b0;
        done = 1'b0;
        tready = 1'b1;
        start_trig(8, 2);
        for (int k = 0; k < 300; k++) begin
            tready = pat[k % 4];
            if (tvalid === 1'b1) begin
                checks++;
                if (beats >= 16 || tdata !== DW'(beats % 8)) begin
                    failures++; $display("FAIL bp_data[%0d]: got %0d want %0d", beats, tdata, beats % 8);
                end
            end
            if (prev_stall && tvalid !== 1'b1) begin
                checks++;
                failures++; $display("FAIL bp_valid_drop: tvalid=%b want 1 at cycle %0d", tvalid, k);
            end
            if (tvalid === 1'b1 && tready === 1'b1) beats++;
            prev_stall = (tvalid === 1'b1) && (tready === 1'b0);
            if (k > 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        tready = 1'b1;
        checks++;
        if (!done || beats != 16 || sts_loops !== 16'd2) begin
            failures++; $display("FAIL bp_total: done=%b beats=%0d loops=%0d want 1 16 2", done, beats, sts_loops);
        end
    endtask

    task automatic test_edges();
        int act;
        int bad;
        // zero length never starts
        start_trig(0, 1);
        act = (busy === 1'b1) ? 1 : 0;
        repeat (8) begin
            tick();
            if (busy !== 1'b0 || tvalid !== 1'b0) act++;
        end
        checks++;
        if (act != 0) begin
            failures++; $display("FAIL zero_length: got %0d active cycles want 0", act);
        end
        // trig and stop together
        cfg_length = LW'(4); cfg_loops = 16'd1;
        trig = 1'b1; stop = 1'b1;
        tick();
        trig = 1'b0; stop = 1'b0;
        act = 0;
        repeat (8) begin
            tick();
            if (busy !== 1'b0 || tvalid !== 1'b0) act++;
        end
        checks++;
        if (act != 0) begin
            failures++; $display("FAIL trig_with_stop: got %0d active cycles want 0", act);
        end
        // trig held high starts once
        trig = 1'b1;
        tick();
        run_capture(40);
        act = 0;
        repeat (8) begin
            tick();
            if (busy !== 1'b0 || tvalid !== 1'b0) act++;
        end
        trig = 1'b0;
        tick();
        checks++;
        if (beat_q.size() != 4 || busy_fall_k != 8 || act != 0) begin
            failures++; $display("FAIL trig_held: beats=%0d fall=%0d extra=%0d want 4 8 0", beat_q.size(), busy_fall_k, act);
        end
        // trig edge and cfg change during PLAY are ignored
        start_trig(4, 2);
        tick();
        trig = 1'b1; cfg_length = LW'(2); cfg_loops = 16'd1;
        tick();
        trig = 1'b0;
        run_capture(40);
        checks++;
        if (beat_q.size() != 8 || first_k != 2 || busy_fall_k != 10) begin
            failures++; $display("FAIL trig_in_play: beats=%0d first=%0d fall=%0d want 8 2 10", beat_q.size(), first_k, busy_fall_k);
        end
        for (int i = 0; i < beat_q.size() && i < 8; i++) begin
            checks++;
            if (beat_q[i] !== DW'(i % 4)) begin
                failures++; $display("FAIL trig_in_play_data[%0d]: got %0d want %0d", i, beat_q[i], i % 4);
            end
        end
        // single-word waveform repeats back to back
        start_trig(1, 3);
        run_capture(20);
        bad = 0;
        foreach (beat_q[i]) if (beat_q[i] !== DW'(0)) bad++;
        checks++;
        if (beat_q.size() != 3 || first_k != 4 || busy_fall_k != 7 || bad != 0) begin
            failures++; $display("FAIL length_one: beats=%0d first=%0d fall=%0d bad=%0d want 3 4 7 0", beat_q.size(), first_k, busy_fall_k, bad);
        end
        // full address space
        start_trig(1 << AW, 1);
        run_capture(4200);
        bad = 0;
        foreach (beat_q[i]) if (beat_q[i] !== DW'(i)) bad++;
        checks++;
        if (beat_q.size() != 4096 || busy_fall_k != 4100 || bad != 0 || sts_addr !== AW'(4095) || sts_loops !== 16'd1) begin
            failures++; $display("FAIL max_length: beats=%0d fall=%0d bad=%0d addr=%0d loops=%0d want 4096 4100 0 4095 1",
                                 beat_q.size(), busy_fall_k, bad, sts_addr, sts_loops);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW+AW+AW+17:0] got;
        start_trig(5, 0);
        repeat (6) tick();
        areset = 1'b1;
        #1;
        got = {busy, tvalid, tdata, bram_addr, sts_addr, sts_loops};
        checks++;
        if (got !== '0) begin
            failures++; $display("FAIL reset_mid: got %h want 0", got);
        end
        #2;
        areset = 1'b0;
        tick();
        start_trig(4, 1);
        run_capture(30);
        checks++;
        if (beat_q.size() != 4 || first_k != L + 2 || busy_fall_k != 8) begin
            failures++; $display("FAIL reset_restart: beats=%0d first=%0d fall=%0d want 4 %0d 8", beat_q.size(), first_k, busy_fall_k, L + 2);
        end
        for (int i = 0; i < beat_q.size() && i < 4; i++) begin
            checks++;
            if (beat_q[i] !== DW'(i)) begin
                failures++; $display("FAIL reset_restart_data[%0d]: got %0d want %0d", i, beat_q[i], i);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        test_reset();
        test_single_pass();
        test_loop();
        test_abort();
        test_backpressure();
        test_edges();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
